// File: rtl/difficulty_select.sv
// Debounces the five board push-buttons and maintains the game difficulty (1..3)
// read by the processor; also exports debounced levels and press pulses.
module difficulty_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int RESET_DIFF      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        BTNL,
  input  logic        BTNC,
  input  logic        BTNR,
  input  logic        BTNU,
  input  logic        BTND,
  output logic [4:0]  btn_level,
  output logic [4:0]  btn_pressed,
  output logic [31:0] difficulty,
  output logic        difficulty_changed
);

  localparam int NUM_BTN = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    BIT_L = 3'd0,
    BIT_C = 3'd1,
    BIT_R = 3'd2,
    BIT_D = 3'd3,
    BIT_U = 3'd4
  } btn_bit_e;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [CNT_W-1:0]   cnt      [NUM_BTN];
  logic [CNT_W-1:0]   cnt_nxt  [NUM_BTN];
  logic [NUM_BTN-1:0] level_nxt;
  logic [1:0]         diff_q;
  logic [1:0]         diff_nxt;

  assign raw = {BTNU, BTND, BTNR, BTNC, BTNL};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      level_nxt[i] = btn_level[i];
      cnt_nxt[i]   = '0;
      if (sync2[i] != btn_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Direct selects win over stepping; U and D together cancel out.
  always_comb begin
    diff_nxt = diff_q;
    if (btn_pressed[BIT_L]) begin
      diff_nxt = 2'd1;
    end else if (btn_pressed[BIT_C]) begin
      diff_nxt = 2'd2;
    end else if (btn_pressed[BIT_R]) begin
      diff_nxt = 2'd3;
    end else if (btn_pressed[BIT_U] && !btn_pressed[BIT_D]) begin
      diff_nxt = (diff_q == 2'd3) ? 2'd3 : diff_q + 2'd1;
    end else if (btn_pressed[BIT_D] && !btn_pressed[BIT_U]) begin
      diff_nxt = (diff_q == 2'd1) ? 2'd1 : diff_q - 2'd1;
    end
  end

  // NOTE: all state updates are non-blocking so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1              <= '0;
      sync2              <= '0;
      btn_level          <= '0;
      btn_pressed        <= '0;
      diff_q             <= 2'(RESET_DIFF);
      difficulty_changed <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1              <= raw;
      sync2              <= sync1;
      btn_level          <= level_nxt;
      // Pulse lands in the same cycle the level first reads 1.
      btn_pressed        <= level_nxt & ~btn_level;
      diff_q             <= diff_nxt;
      difficulty_changed <= (diff_nxt != diff_q);
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign difficulty = {30'd0, diff_q};

endmodule

// File: tb/tb_difficulty_select.sv
// Scoreboarded bench for difficulty_select with a short debounce window:
// stimulus queues expected pulses with their cycle, a monitor pops and compares.
module tb_difficulty_select;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        BTNL  = 1'b0;
  logic        BTNC  = 1'b0;
  logic        BTNR  = 1'b0;
  logic        BTNU  = 1'b0;
  logic        BTND  = 1'b0;
  logic [4:0]  btn_level;
  logic [4:0]  btn_pressed;
  logic [31:0] difficulty;
  logic        difficulty_changed;

  difficulty_select #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .RESET_DIFF     (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .BTNL              (BTNL),
    .BTNC              (BTNC),
    .BTNR              (BTNR),
    .BTNU              (BTNU),
    .BTND              (BTND),
    .btn_level         (btn_level),
    .btn_pressed       (btn_pressed),
    .difficulty        (difficulty),
    .difficulty_changed(difficulty_changed)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] vec;
    int         at;
  } press_t;

  typedef struct {
    logic [31:0] val;
    int          at;
  } diff_t;

  press_t press_q[$];
  diff_t  diff_q[$];
  press_t mon_p;
  diff_t  mon_d;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] v);
    {BTNU, BTND, BTNR, BTNC, BTNL} = v;
  endtask

  // Level rises 6 edges after a drive, the difficulty register one edge later.
  task automatic expect_at(input int e0, input logic [4:0] v, input int exp_diff);
    press_q.push_back('{vec: v, at: e0 + DEB + 2});
    if (exp_diff != 0) diff_q.push_back('{val: 32'(exp_diff), at: e0 + DEB + 3});
  endtask

  task automatic press(input logic [4:0] v, input int exp_diff);
    expect_at(cyc, v, exp_diff);
    drive(v);
    tick(10);
    drive(5'b0);
    tick(10);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (btn_pressed != 5'b0) begin
        if (press_q.size() == 0) begin
          check("unexpected_press", {27'd0, btn_pressed}, 32'd0);
        end else begin
          mon_p = press_q.pop_front();
          check("press_vec", {27'd0, btn_pressed}, {27'd0, mon_p.vec});
          check("press_cycle", cyc, mon_p.at);
        end
      end
      if (difficulty_changed) begin
        if (diff_q.size() == 0) begin
          check("unexpected_change", difficulty, 32'd0);
        end else begin
          mon_d = diff_q.pop_front();
          check("diff_value", difficulty, mon_d.val);
          check("diff_cycle", cyc, mon_d.at);
        end
      end
    end
  end

  initial begin
    int e0;
    int r;

    // 1: reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_difficulty", difficulty, 32'd1);
    check("rst_level", {27'd0, btn_level}, 32'd0);
    check("rst_pressed", {27'd0, btn_pressed}, 32'd0);
    check("rst_changed", {31'd0, difficulty_changed}, 32'd0);

    // 2: BTNC held, exact latency
    e0 = cyc;
    expect_at(e0, 5'b00010, 2);
    drive(5'b00010);
    tick(5);
    check("c_level_early", {27'd0, btn_level}, 32'd0);
    tick(1);
    check("c_level_edge6", {27'd0, btn_level}, 32'd2);
    tick(1);
    check("c_pulse_one_cycle", {27'd0, btn_pressed}, 32'd0);
    check("c_difficulty", difficulty, 32'd2);
    tick(1);
    check("c_changed_one_cycle", {31'd0, difficulty_changed}, 32'd0);
    tick(7);
    drive(5'b0);
    tick(10);

    // 3: 3-cycle glitch on BTNR is rejected, a held BTNR is accepted
    drive(5'b00100);
    tick(3);
    drive(5'b0);
    tick(10);
    check("glitch_level", {27'd0, btn_level}, 32'd0);
    check("glitch_difficulty", difficulty, 32'd2);
    press(5'b00100, 3);

    // 4: saturation at both ends
    press(5'b10000, 0);
    press(5'b01000, 2);
    press(5'b01000, 1);
    press(5'b01000, 0);
    check("sat_low", difficulty, 32'd1);

    // 5: priority and U+D cancel
    press(5'b00010, 2);
    press(5'b00101, 1);
    press(5'b11000, 0);
    press(5'b10000, 2);
    press(5'b11000, 0);
    check("ud_cancel", difficulty, 32'd2);
    press(5'b00100, 3);

    // 6: reset in mid-debounce with BTNC held
    drive(5'b00010);
    tick(5);
    reset = 1'b1;
    tick(2);
    check("mid_rst_difficulty", difficulty, 32'd1);
    check("mid_rst_level", {27'd0, btn_level}, 32'd0);
    check("mid_rst_changed", {31'd0, difficulty_changed}, 32'd0);
    reset = 1'b0;
    r = cyc;
    expect_at(r, 5'b00010, 2);
    tick(5);
    check("post_rst_level_early", {27'd0, btn_level}, 32'd0);
    tick(1);
    check("post_rst_level", {27'd0, btn_level}, 32'd2);
    tick(1);
    check("post_rst_difficulty", difficulty, 32'd2);
    tick(10);
    drive(5'b0);
    tick(10);

    check("press_queue_empty", press_q.size(), 32'd0);
    check("diff_queue_empty", diff_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
